// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: accepts one rectangle command and writes each pixel
// in raster order to the framebuffer write port, one per granted cycle.
module fb_rect_fill #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned COLOR_BITS = 4,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [XW-1:0]         cmd_x1,
  input  logic [YW-1:0]         cmd_y1,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic                  fb_we,
  output logic [XW+YW-1:0]      fb_waddr,
  output logic [COLOR_BITS-1:0] fb_din,
  input  logic                  fb_grant,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state;
  logic [XW-1:0]         xl, xh, x;
  logic [YW-1:0]         yl, yh, y;
  logic [COLOR_BITS-1:0] color;

  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;

  always_comb begin
    x_min = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    x_max = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    y_min = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    y_max = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      xl    <= '0;
      xh    <= '0;
      yl    <= '0;
      yh    <= '0;
      x     <= '0;
      y     <= '0;
      color <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            xl    <= x_min;
            xh    <= x_max;
            yl    <= y_min;
            yh    <= y_max;
            x     <= x_min;
            y     <= y_min;
            color <= cmd_color;
            state <= WRITE;
          end
        end
        WRITE: begin
          // Cursor only moves on a granted write; otherwise address/data hold.
          if (fb_grant) begin
            if (x != xh) begin
              x <= x + XW'(1);
            end else if (y != yh) begin
              x <= xl;
              y <= y + YW'(1);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fb_we     = (state == WRITE);
  assign done      = (state == DONE);
  assign fb_waddr  = {y, x};
  assign fb_din    = color;

endmodule
